alu_share_ctrl: RTL

Two-requester sharing controller for the 32-bit ALU datapath. It accepts operation requests (operands plus 4-bit ALU control code) from two independent requesters over valid/ready handshakes. It grants the single ALU round-robin, drives the ALU inputs from registers, captures the ALU result and zero flag, and returns them to the granted requester over a valid/ready response handshake. It sits between the execute-stage issue logic and the combinational ALU.

---
 rtl/alu_share_pkg.sv | 26 ++
 rtl/alu_share_ctrl_arb.sv | 19 +
 rtl/alu_share_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/alu_share_pkg.sv
// Shared types and ALU control codes for the two-requester ALU sharing controller.
// The illegal-opcode check (alu_ctl_legal) is only used when ALU_OPCHK_EN is defined.
package alu_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  function automatic logic alu_ctl_legal(input logic [3:0] ctl);
    logic legal;
    case (ctl)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: legal = 1'b1;
      default:                                    legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_arb.sv
// Combinational 2-way round-robin grant: a lone requester always wins,
// a tie goes to the requester named by prio. Grant is one-hot or zero.
module alu_rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters (IDLE -> EXEC -> RESP).
// Optional macro ALU_OPCHK_EN: reject illegal ctl codes with rsp_err instead of executing.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CTL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [CTL_W-1:0] req_ctl0,
  input  logic [CTL_W-1:0] req_ctl1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [CTL_W-1:0] alu_ctl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [1:0]       alu_zero,
  output logic [1:0]       dbg_state_o,
  output logic             dbg_prio_o,
  output logic             dbg_owner_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // Requesters hold valid and data stable until ready; responses hold until rsp_ready[owner].

  state_e           state_q;
  logic             prio_q;
  logic             owner_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CTL_W-1:0] ctl_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic [1:0]       gnt;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [CTL_W-1:0] sel_ctl;
  logic             unused_zero_hi;

  assign unused_zero_hi = alu_zero[1];

  alu_rr_arb2 u_arb (
    .req  (req_valid),
    .prio (prio_q),
    .gnt  (gnt)
  );

  assign sel_a   = gnt[1] ? req_a1   : req_a0;
  assign sel_b   = gnt[1] ? req_b1   : req_b0;
  assign sel_ctl = gnt[1] ? req_ctl1 : req_ctl0;

  assign req_ready = (state_q == IDLE && !rst) ? gnt : 2'b00;
  assign rsp_valid = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

  assign rsp_result  = result_q;
  assign rsp_zero    = zero_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_ctl     = ctl_q;
  assign dbg_state_o = state_q;
  assign dbg_prio_o  = prio_q;
  assign dbg_owner_o = owner_q;

`ifdef ALU_OPCHK_EN
  logic err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      ctl_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
`ifdef ALU_OPCHK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            owner_q <= gnt[1];
`ifdef ALU_OPCHK_EN
            // Illegal codes never reach the ALU; the error response skips EXEC.
            if (!alu_ctl_legal(sel_ctl)) begin
              result_q <= '0;
              zero_q   <= 1'b0;
              err_q    <= 1'b1;
              state_q  <= RESP;
            end else begin
              a_q     <= sel_a;
              b_q     <= sel_b;
              ctl_q   <= sel_ctl;
              state_q <= EXEC;
            end
`else
            a_q     <= sel_a;
            b_q     <= sel_b;
            ctl_q   <= sel_ctl;
            state_q <= EXEC;
`endif
          end
        end
        EXEC: begin
          result_q <= alu_out;
          zero_q   <= alu_zero[0];
`ifdef ALU_OPCHK_EN
          err_q    <= 1'b0;
`endif
          state_q  <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner_q]) begin
            prio_q  <= ~owner_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
